// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The requester drives start/mode/a/b; the arithmetic unit returns status and result.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, carry, overflow, zero
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, carry, overflow, zero
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder stage reused
// over WIDTH cycles, committing result and carry/overflow/zero flags on done.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             c_msb_q, c_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] op_a_shr;
    logic [WIDTH-1:0] op_b_shr;
    logic [WIDTH-1:0] sum_shift;
    logic             bit_s;
    logic             bit_c;

    // The single full-adder stage operating on the current LSBs.
    assign bit_s = op_a_q[0] ^ op_b_q[0] ^ c_q;
    assign bit_c = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & c_q) | (op_b_q[0] & c_q);

    // Operands drain LSB first; the sum fills from the MSB end.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign op_a_shr[gi]  = op_a_q[gi+1];
            assign op_b_shr[gi]  = op_b_q[gi+1];
            assign sum_shift[gi] = sum_q[gi+1];
        end
    endgenerate
    assign op_a_shr[WIDTH-1]  = 1'b0;
    assign op_b_shr[WIDTH-1]  = 1'b0;
    assign sum_shift[WIDTH-1] = bit_s;

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        c_msb_d  = c_msb_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Subtract is a + ~b + 1: invert B and inject mode as carry-in.
                    op_a_d  = bus.a;
                    op_b_d  = bus.b ^ {WIDTH{bus.mode}};
                    c_d     = bus.mode;
                    cnt_d   = '0;
                    sum_d   = '0;
                    c_msb_d = 1'b0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                sum_d  = sum_shift;
                op_a_d = op_a_shr;
                op_b_d = op_b_shr;
                c_d    = bit_c;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_MSB_IN) begin
                    c_msb_d = bit_c;
                end
                if (cnt_q == CNT_LAST) begin
                    result_d = sum_shift;
                    carry_d  = bit_c;
                    ovf_d    = c_msb_q ^ bit_c;
                    zero_d   = ~|sum_shift;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            c_msb_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            c_msb_q  <= c_msb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule
